// File: rtl/seq_event_monitor_if.sv
// Result port of the windowed event monitor.
// The producer drives valid/count/alarm/ovr and the consumer drives ready.
interface seq_event_monitor_if #(
   parameter int CNT_W = 8
);
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] res_count;
   logic             res_alarm;
   logic             res_ovr;

   modport master (
      output res_valid,
      output res_count,
      output res_alarm,
      output res_ovr,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_count,
      input  res_alarm,
      input  res_ovr,
      output res_ready
   );
endinterface

// File: rtl/seq_event_monitor.sv
// Windowed counter of detector pulses.
// Each closed window is published as count/alarm/overrun on a valid/ready result port.
module seq_event_monitor #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 det,
   input  logic [WIN_W-1:0]     win_len,
   input  logic [CNT_W-1:0]     thresh,
   seq_event_monitor_if.master  res
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
   localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Saturating increment: the event count holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                input logic             inc);
      logic [CNT_W-1:0] result;
      if (inc && (value != CNT_MAX)) begin
         result = value + CNT_ONE;
      end else begin
         result = value;
      end
      return result;
   endfunction

   state_t           state_r,     state_nx;
   logic [WIN_W-1:0] win_cnt_r,   win_cnt_nx;
   logic [CNT_W-1:0] evt_cnt_r,   evt_cnt_nx;
   logic [WIN_W-1:0] len_r,       len_nx;
   logic             res_valid_r, res_valid_nx;
   logic [CNT_W-1:0] res_count_r, res_count_nx;
   logic             res_alarm_r, res_alarm_nx;
   logic             res_ovr_r,   res_ovr_nx;

   logic [CNT_W-1:0] evt_next_s;
   logic [WIN_W-1:0] len_eff_s;
   logic             alarm_s;
   logic             xfer_s;
   logic             close_s;

   // Per-edge arithmetic shared by the window and result logic.
   always_comb begin
      evt_next_s = sat_inc(evt_cnt_r, det);
      if (win_len == WIN_ZERO) begin
         len_eff_s = WIN_ONE;
      end else begin
         len_eff_s = win_len;
      end
      alarm_s = (thresh != CNT_ZERO) && (evt_next_s >= thresh);
      xfer_s  = res_valid_r && res.res_ready;
   end

   // Window FSM: start, count, close and abandon on enable drop.
   always_comb begin
      state_nx   = state_r;
      win_cnt_nx = win_cnt_r;
      evt_cnt_nx = evt_cnt_r;
      len_nx     = len_r;
      close_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               // The det seen on the starting edge is deliberately not counted.
               state_nx   = ST_RUN;
               win_cnt_nx = WIN_ZERO;
               evt_cnt_nx = CNT_ZERO;
               len_nx     = len_eff_s;
            end else begin
               win_cnt_nx = WIN_ZERO;
               evt_cnt_nx = CNT_ZERO;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_nx   = ST_IDLE;
               win_cnt_nx = WIN_ZERO;
               evt_cnt_nx = CNT_ZERO;
            end else if (win_cnt_r == (len_r - WIN_ONE)) begin
               close_s    = 1'b1;
               win_cnt_nx = WIN_ZERO;
               evt_cnt_nx = CNT_ZERO;
               len_nx     = len_eff_s;
            end else begin
               win_cnt_nx = win_cnt_r + WIN_ONE;
               evt_cnt_nx = evt_next_s;
            end
         end
         default: begin
            state_nx   = ST_IDLE;
            win_cnt_nx = WIN_ZERO;
            evt_cnt_nx = CNT_ZERO;
            len_nx     = WIN_ONE;
         end
      endcase
   end

   // Result register: load on close, release on transfer, flag overwrites.
   always_comb begin
      res_valid_nx = res_valid_r;
      res_count_nx = res_count_r;
      res_alarm_nx = res_alarm_r;
      res_ovr_nx   = res_ovr_r;
      if (close_s) begin
         res_valid_nx = 1'b1;
         res_count_nx = evt_next_s;
         res_alarm_nx = alarm_s;
         res_ovr_nx   = res_valid_r && !res.res_ready;
      end else if (xfer_s) begin
         res_valid_nx = 1'b0;
      end else begin
         res_valid_nx = res_valid_r;
      end
   end

   // State and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         win_cnt_r   <= WIN_ZERO;
         evt_cnt_r   <= CNT_ZERO;
         len_r       <= WIN_ONE;
         res_valid_r <= 1'b0;
         res_count_r <= CNT_ZERO;
         res_alarm_r <= 1'b0;
         res_ovr_r   <= 1'b0;
      end else begin
         state_r     <= state_nx;
         win_cnt_r   <= win_cnt_nx;
         evt_cnt_r   <= evt_cnt_nx;
         len_r       <= len_nx;
         res_valid_r <= res_valid_nx;
         res_count_r <= res_count_nx;
         res_alarm_r <= res_alarm_nx;
         res_ovr_r   <= res_ovr_nx;
      end
   end

   assign res.res_valid = res_valid_r;
   assign res.res_count = res_count_r;
   assign res.res_alarm = res_alarm_r;
   assign res.res_ovr   = res_ovr_r;

endmodule

// File: tb/tb_seq_event_monitor.sv
// Bench for seq_event_monitor: a vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based window model.
module tb_seq_event_monitor;

   localparam int CNT_W   = 8;
   localparam int WIN_W   = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             enable;
   logic             det;
   logic [WIN_W-1:0] win_len;
   logic [CNT_W-1:0] thresh;
   logic             ready;

   seq_event_monitor_if #(.CNT_W(CNT_W)) res_if ();
   assign res_if.res_ready = ready;

   seq_event_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .det     (det),
      .win_len (win_len),
      .thresh  (thresh),
      .res     (res_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // Reference model: collects the det values of the open window and sums them at close.
   bit m_run;
   bit m_win[$];
   int m_len;
   bit m_valid;
   int m_count;
   bit m_alarm;
   bit m_ovr;

   typedef struct {
      logic             en;
      logic             d;
      logic [WIN_W-1:0] wl;
      logic [CNT_W-1:0] th;
      logic             rdy;
      logic             ev;
      int               ec;
      logic             ea;
      logic             eo;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run   = 1'b0;
      m_win.delete();
      m_len   = 1;
      m_valid = 1'b0;
      m_count = 0;
      m_alarm = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_step();
      bit xfer;
      bit closed;
      int sum;
      xfer   = m_valid && ready;
      closed = 1'b0;
      if (!m_run) begin
         if (enable) begin
            m_run = 1'b1;
            m_win.delete();
            m_len = (win_len == 0) ? 1 : int'(win_len);
         end
      end else if (!enable) begin
         m_run = 1'b0;
         m_win.delete();
      end else begin
         m_win.push_back(det);
         if (m_win.size() == m_len) begin
            sum = 0;
            foreach (m_win[i]) sum += int'(m_win[i]);
            if (sum > CNT_MAX) sum = CNT_MAX;
            closed  = 1'b1;
            m_ovr   = m_valid && !xfer;
            m_valid = 1'b1;
            m_count = sum;
            m_alarm = (thresh != 0) && (sum >= int'(thresh));
            m_win.delete();
            m_len = (win_len == 0) ? 1 : int'(win_len);
         end
      end
      if (!closed && xfer) m_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("valid", int'(res_if.res_valid), int'(m_valid));
      if (m_valid) begin
         check("count", int'(res_if.res_count), m_count);
         check("alarm", int'(res_if.res_alarm), int'(m_alarm));
         check("ovr",   int'(res_if.res_ovr),   int'(m_ovr));
      end
   endtask

   task automatic async_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_valid", int'(res_if.res_valid), 0);
      check("rst_count", int'(res_if.res_count), 0);
      check("rst_alarm", int'(res_if.res_alarm), 0);
      check("rst_ovr",   int'(res_if.res_ovr),   0);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   task automatic add_vec(input logic d, input logic ev, input int ec, input logic ea);
      vec_t v;
      v.en = 1'b1; v.d = d; v.wl = 16'd8; v.th = 8'd3; v.rdy = 1'b1;
      v.ev = ev; v.ec = ec; v.ea = ea; v.eo = 1'b0;
      tbl.push_back(v);
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      enable  = 1'b0;
      det     = 1'b0;
      win_len = 16'd0;
      thresh  = 8'd0;
      ready   = 1'b0;
      model_reset();

      // Basic windows: 3 of 8 then 2 of 8 with thresh 3; valid lasts one cycle.
      add_vec(1'b1, 1'b0, 0, 1'b0);
      add_vec(1'b1, 1'b0, 0, 1'b0);
      add_vec(1'b0, 1'b0, 0, 1'b0);
      add_vec(1'b1, 1'b0, 0, 1'b0);
      add_vec(1'b0, 1'b0, 0, 1'b0);
      add_vec(1'b0, 1'b0, 0, 1'b0);
      add_vec(1'b1, 1'b0, 0, 1'b0);
      add_vec(1'b0, 1'b0, 0, 1'b0);
      add_vec(1'b0, 1'b1, 3, 1'b1);
      add_vec(1'b0, 1'b0, 0, 1'b0);
      add_vec(1'b1, 1'b0, 0, 1'b0);
      add_vec(1'b0, 1'b0, 0, 1'b0);
      add_vec(1'b0, 1'b0, 0, 1'b0);
      add_vec(1'b0, 1'b0, 0, 1'b0);
      add_vec(1'b1, 1'b0, 0, 1'b0);
      add_vec(1'b0, 1'b0, 0, 1'b0);
      add_vec(1'b0, 1'b1, 2, 1'b0);

      #12;
      check("por_valid", int'(res_if.res_valid), 0);
      rst_n = 1'b1;

      // Reset mid-cycle while running, then idle with det toggling.
      enable = 1'b1; det = 1'b1; win_len = 16'd8;
      tick();
      tick();
      async_reset();
      enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         det = i[0];
         tick();
      end

      for (int i = 0; i < tbl.size(); i++) begin
         enable = tbl[i].en; det = tbl[i].d; win_len = tbl[i].wl;
         thresh = tbl[i].th; ready = tbl[i].rdy;
         tick();
         check("tbl_valid", int'(res_if.res_valid), int'(tbl[i].ev));
         if (tbl[i].ev) begin
            check("tbl_count", int'(res_if.res_count), tbl[i].ec);
            check("tbl_alarm", int'(res_if.res_alarm), int'(tbl[i].ea));
            check("tbl_ovr",   int'(res_if.res_ovr),   int'(tbl[i].eo));
         end
      end

      // Saturation: 300 cycles of det with an 8-bit count.
      enable = 1'b0; ready = 1'b1;
      tick();
      enable = 1'b1; det = 1'b1; win_len = 16'd300; thresh = 8'd0;
      for (int i = 0; i < 301; i++) tick();
      check("sat_valid", int'(res_if.res_valid), 1);
      check("sat_count", int'(res_if.res_count), 255);
      check("sat_alarm", int'(res_if.res_alarm), 0);

      // win_len 0 behaves as 1: a result every cycle.
      enable = 1'b0;
      tick();
      enable = 1'b1; win_len = 16'd0; det = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("len0_valid", int'(res_if.res_valid), 1);
         check("len0_count", int'(res_if.res_count), 1);
         check("len0_ovr",   int'(res_if.res_ovr),   0);
      end

      // Backpressure over three windows, then ready on the fourth close edge.
      enable = 1'b0;
      tick();
      enable = 1'b1; win_len = 16'd4; thresh = 8'd2; ready = 1'b0;
      tick();
      for (int i = 1; i <= 16; i++) begin
         det   = 1'($urandom_range(0, 1));
         ready = (i == 16);
         tick();
         if (i == 4)  check("bp_ovr1", int'(res_if.res_ovr), 0);
         if (i == 8)  check("bp_ovr2", int'(res_if.res_ovr), 1);
         if (i == 12) check("bp_ovr3", int'(res_if.res_ovr), 1);
         if (i >= 4)  check("bp_valid", int'(res_if.res_valid), 1);
         if (i == 16) check("bp_ovr4", int'(res_if.res_ovr), 0);
      end
      ready = 1'b1; det = 1'b0;
      tick();
      check("bp_drain", int'(res_if.res_valid), 0);

      // Enable drop discards a partial window; the re-enable det is not counted.
      enable = 1'b0;
      tick();
      enable = 1'b1; win_len = 16'd10; thresh = 8'd1; det = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
         det = (i == 1) || (i == 4);
         tick();
      end
      enable = 1'b0; det = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drop_valid", int'(res_if.res_valid), 0);
      end
      enable = 1'b1; det = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         det = (i == 2);
         tick();
      end
      check("reen_valid", int'(res_if.res_valid), 1);
      check("reen_count", int'(res_if.res_count), 1);
      check("reen_alarm", int'(res_if.res_alarm), 1);

      // Reset while a result is pending, then a fresh window.
      ready = 1'b0; win_len = 16'd4; det = 1'b1;
      tick();
      tick();
      async_reset();
      tick();
      for (int i = 0; i < 4; i++) tick();
      check("post_rst_valid", int'(res_if.res_valid), 1);
      check("post_rst_ovr",   int'(res_if.res_ovr),   0);
      check("post_rst_count", int'(res_if.res_count), 4);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         enable  = ($urandom_range(0, 19) != 0);
         det     = 1'($urandom_range(0, 1));
         ready   = ($urandom_range(0, 2) != 0);
         win_len = 16'($urandom_range(0, 6));
         thresh  = 8'($urandom_range(0, 4));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_event_monitor.md
# seq_event_monitor

Windowed event counter placed directly downstream of the serial sequence detector. It counts the single-cycle detection pulses the detector produces over a programmable window of clock cycles. At each window close it presents the count, a threshold alarm and an overrun flag on a valid/ready result port. The result port feeds the status/readout logic.

## Interface
Parameters:
- CNT_W, 8, width of event count and threshold
- WIN_W, 16, width of window length

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk by upstream reset logic)
- enable  input  1  1 = monitor running; 0 = idle, partial window discarded
- det  input  1  detection pulse from sequence detector; each cycle high counts one event
- win_len  input  WIN_W  window length in cycles; sampled at window start; 0 treated as 1
- thresh  input  CNT_W  alarm threshold; 0 disables alarm
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_count  output  CNT_W  events in closed window, saturating
- res_alarm  output  1  thresh != 0 and res_count >= thresh
- res_ovr  output  1  this result overwrote an unaccepted one

## Operation
- FSM states: IDLE, RUN.
- IDLE -> RUN on a clock edge with enable=1. On that edge: win_cnt<=0, evt_cnt<=0, L<=max(win_len,1). det on that edge is not counted.
- RUN -> IDLE on any edge with enable=0. win_cnt and evt_cnt are cleared, no result is produced, and the result register is untouched.
- RUN, each edge with enable=1:
  - evt_next = sat(evt_cnt + det), saturating at 2^CNT_W-1.
  - If win_cnt == L-1 (window close): load the result with res_count<=evt_next and res_alarm<=(thresh!=0 && evt_next>=thresh), using thresh sampled on this edge. Clear evt_cnt and win_cnt, and resample L from win_len.
  - Otherwise: evt_cnt<=evt_next, win_cnt<=win_cnt+1.
- Windows are back-to-back with no gap cycle. Each det cycle in RUN is counted in exactly one window.
- Result handshake:
  - A transfer occurs on an edge where res_valid=1 and res_ready=1.
  - res_valid, res_count and res_alarm are held stable until transfer.
  - After a transfer with no new result loaded on that edge, res_valid<=0.
- Window close, by condition on the same edge:
  - res_valid=0: load, res_valid<=1, res_ovr<=0.
  - res_valid=1 and transfer occurs: the old result is consumed and the new one loaded; res_valid stays 1, res_ovr<=0.
  - res_valid=1 and no transfer: the old result is overwritten, res_ovr<=1.
- The result register is not cleared by enable=0. A pending result remains available for transfer while in IDLE.
- Width rules:
  - win_cnt is WIN_W bits and never exceeds L-1.
  - evt_cnt never wraps; it holds at all-ones.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, win_cnt=0, evt_cnt=0, res_valid=0, res_count=0, res_alarm=0, res_ovr=0.
- Reset mid-window or mid-handshake: all state is lost and any pending result is dropped.
- Latency: res_valid rises on the edge that samples the window's last det cycle. The result is visible in the following cycle.
- Edge E0 (enable seen high in IDLE) is followed by windows. Window n covers the det values sampled at edges E0+1+n·L through E0+(n+1)·L.
- win_len or thresh changes mid-window have no effect on the current window length. thresh is applied at the close edge.
- res_ready is a don't-care while res_valid=0.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; after release with enable=0 and det toggling -> res_valid stays 0.
- Basic window: win_len=8, thresh=3, res_ready=1, det high on 3 of 8 cycles -> one result with res_count=3, res_alarm=1, res_ovr=0, res_valid high exactly 1 cycle; repeat with 2 pulses -> count=2, alarm=0.
- Saturation/edges: CNT_W=8, win_len=300, det held high -> res_count=255; win_len=0 with det=1 -> a result every cycle with count=1; thresh=0 -> res_alarm never asserts.
- Backpressure: win_len=4, res_ready=0 for 3 windows -> res_valid stays high, res_count tracks the latest window, res_ovr=1 from the second close on; raise res_ready on a close edge -> res_ovr=0 and res_valid stays 1.
- Enable drop: win_len=10, enable=0 after 6 cycles with 2 det pulses -> no result; re-enable -> the new window starts at count 0, and the det sampled on the enable edge is not counted.
- Reset mid-handshake: res_valid=1 pending, pulse rst_n low -> res_valid=0; a subsequent window produces a fresh result with res_ovr=0.
